// File: rtl/reg_file_sb_if.sv
// Register file bus: decode reads/reservations and writeback writes.
// The master drives requests; the register file (slave) answers.
interface reg_file_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic [NUM_RD*ADDR_W-1:0] ip_rs_addr;
    logic [NUM_RD*DATA_W-1:0] op_rs_data;
    logic [NUM_RD-1:0]        op_rs_busy;
    logic                     ip_wra_en;
    logic [ADDR_W-1:0]        ip_wra_addr;
    logic [DATA_W-1:0]        ip_wra_data;
    logic                     ip_wrb_en;
    logic [ADDR_W-1:0]        ip_wrb_addr;
    logic [DATA_W-1:0]        ip_wrb_data;
    logic                     ip_rsv_en;
    logic [ADDR_W-1:0]        ip_rsv_addr;
    logic [2**ADDR_W-1:0]     op_busy_vec;
    logic                     op_err;

    modport master (
        output ip_rs_addr,
        output ip_wra_en, ip_wra_addr, ip_wra_data,
        output ip_wrb_en, ip_wrb_addr, ip_wrb_data,
        output ip_rsv_en, ip_rsv_addr,
        input  op_rs_data, op_rs_busy,
        input  op_busy_vec, op_err
    );

    modport slave (
        input  ip_rs_addr,
        input  ip_wra_en, ip_wra_addr, ip_wra_data,
        input  ip_wrb_en, ip_wrb_addr, ip_wrb_data,
        input  ip_rsv_en, ip_rsv_addr,
        output op_rs_data, op_rs_busy,
        output op_busy_vec, op_err
    );
endinterface

// File: rtl/reg_file_sb.sv
// RV32IM register file: NUM_RD read ports, ALU (A) and MUL/DIV (B)
// write ports, and a per-register busy scoreboard for MUL/DIV results.
module reg_file_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int BYPASS = 1
) (
    input  logic          ip_clk,
    input  logic          ip_rst,
    reg_file_sb_if.slave  bus
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0]        regs [DEPTH];
    logic [DEPTH-1:0]         busy;
    logic [DEPTH-1:0]         busy_nxt;
    logic                     err_q;
    logic                     wra_hit;
    logic                     wrb_hit;
    logic                     rsv_hit;
    logic                     ab_clash;
    logic                     rsv_clash;
    logic                     waw;
    logic [NUM_RD*DATA_W-1:0] rs_data_c;
    logic [NUM_RD-1:0]        rs_busy_c;

    // x0 is never a real target, so every x0 access is filtered here
    assign wra_hit = bus.ip_wra_en && (bus.ip_wra_addr != '0);
    assign wrb_hit = bus.ip_wrb_en && (bus.ip_wrb_addr != '0);
    assign rsv_hit = bus.ip_rsv_en && (bus.ip_rsv_addr != '0);

    assign ab_clash  = wra_hit && wrb_hit &&
                       (bus.ip_wra_addr == bus.ip_wrb_addr);
    assign rsv_clash = rsv_hit && busy[bus.ip_rsv_addr] &&
                       !(wrb_hit &&
                         (bus.ip_wrb_addr == bus.ip_rsv_addr));
    assign waw       = wra_hit && busy[bus.ip_wra_addr];

    // Next scoreboard: a reservation wins over a same-cycle B clear
    always_comb begin
        busy_nxt = busy;
        if (wrb_hit) busy_nxt[bus.ip_wrb_addr] = 1'b0;
        if (rsv_hit) busy_nxt[bus.ip_rsv_addr] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Register array commit; A is written last so it wins on a clash
    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
        end else begin
            if (wrb_hit) regs[bus.ip_wrb_addr] <= bus.ip_wrb_data;
            if (wra_hit) regs[bus.ip_wra_addr] <= bus.ip_wra_data;
        end
    end

    // Scoreboard bits and the registered hazard pulse
    always_ff @(posedge ip_clk) begin
        if (ip_rst) begin
            busy  <= '0;
            err_q <= 1'b0;
        end else begin
            busy  <= busy_nxt;
            err_q <= ab_clash || rsv_clash || waw;
        end
    end

    // Read ports: x0, then A forward, then B forward, then array
    always_comb begin : rd_mux
        logic [ADDR_W-1:0] ra;
        logic              byp_a;
        logic              byp_b;
        rs_data_c = '0;
        rs_busy_c = '0;
        ra        = '0;
        byp_a     = 1'b0;
        byp_b     = 1'b0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra    = bus.ip_rs_addr[i*ADDR_W +: ADDR_W];
            byp_a = (BYPASS != 0) && wra_hit &&
                    (ra == bus.ip_wra_addr);
            byp_b = (BYPASS != 0) && wrb_hit &&
                    (ra == bus.ip_wrb_addr);
            if (ra == '0)
                rs_data_c[i*DATA_W +: DATA_W] = '0;
            else if (byp_a)
                rs_data_c[i*DATA_W +: DATA_W] = bus.ip_wra_data;
            else if (byp_b)
                rs_data_c[i*DATA_W +: DATA_W] = bus.ip_wrb_data;
            else
                rs_data_c[i*DATA_W +: DATA_W] = regs[ra];
            rs_busy_c[i] = busy[ra] && !byp_b;
        end
    end

    assign bus.op_rs_data  = rs_data_c;
    assign bus.op_rs_busy  = rs_busy_c;
    assign bus.op_busy_vec = busy;
    assign bus.op_err      = err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: one BYPASS=1 and one BYPASS=0 register file
// driven by identical stimulus.
module tb_reg_file_sb;
    logic ip_clk_tb = 1'b0;
    logic ip_rst_tb = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 ip_clk_tb = ~ip_clk_tb;

    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_a ();
    reg_file_sb_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) bus_b ();

    assign bus_b.ip_rs_addr  = bus_a.ip_rs_addr;
    assign bus_b.ip_wra_en   = bus_a.ip_wra_en;
    assign bus_b.ip_wra_addr = bus_a.ip_wra_addr;
    assign bus_b.ip_wra_data = bus_a.ip_wra_data;
    assign bus_b.ip_wrb_en   = bus_a.ip_wrb_en;
    assign bus_b.ip_wrb_addr = bus_a.ip_wrb_addr;
    assign bus_b.ip_wrb_data = bus_a.ip_wrb_data;
    assign bus_b.ip_rsv_en   = bus_a.ip_rsv_en;
    assign bus_b.ip_rsv_addr = bus_a.ip_rsv_addr;

    reg_file_sb #(.BYPASS(1)) dut_byp (
        .ip_clk (ip_clk_tb),
        .ip_rst (ip_rst_tb),
        .bus    (bus_a.slave)
    );

    reg_file_sb #(.BYPASS(0)) dut_nob (
        .ip_clk (ip_clk_tb),
        .ip_rst (ip_rst_tb),
        .bus    (bus_b.slave)
    );

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ip_clk_tb);
        #1;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        bus_a.ip_rs_addr = {a1, a0};
        #1;
    endtask

    task automatic idle();
        bus_a.ip_wra_en = 1'b0;
        bus_a.ip_wrb_en = 1'b0;
        bus_a.ip_rsv_en = 1'b0;
    endtask

    task automatic wra(input logic [4:0] a, input logic [31:0] d);
        bus_a.ip_wra_en   = 1'b1;
        bus_a.ip_wra_addr = a;
        bus_a.ip_wra_data = d;
    endtask

    task automatic wrb(input logic [4:0] a, input logic [31:0] d);
        bus_a.ip_wrb_en   = 1'b1;
        bus_a.ip_wrb_addr = a;
        bus_a.ip_wrb_data = d;
    endtask

    task automatic rsv(input logic [4:0] a);
        bus_a.ip_rsv_en   = 1'b1;
        bus_a.ip_rsv_addr = a;
    endtask

    initial begin
        bus_a.ip_rs_addr  = '0;
        bus_a.ip_wra_addr = '0;
        bus_a.ip_wra_data = '0;
        bus_a.ip_wrb_addr = '0;
        bus_a.ip_wrb_data = '0;
        bus_a.ip_rsv_addr = '0;
        idle();

        // reset
        ip_rst_tb = 1'b1;
        tick();
        ip_rst_tb = 1'b0;
        rd(5'd5, 5'd6);
        chk("rst_busy", 64'(bus_a.op_busy_vec), 64'h0);
        chk("rst_err", 64'(bus_a.op_err), 64'h0);
        chk("rst_data", 64'(bus_a.op_rs_data), 64'h0);

        // x5..x8 via port A on consecutive cycles
        for (int i = 0; i < 4; i++) begin
            wra(5'(5 + i), 32'(1 + i));
            tick();
        end
        idle();
        rd(5'd5, 5'd6);
        chk("rd_x5_x6", 64'(bus_a.op_rs_data), 64'h2_0000_0001);
        rd(5'd7, 5'd8);
        chk("rd_x7_x8", 64'(bus_a.op_rs_data), 64'h4_0000_0003);
        chk("rd_x7_nob", 64'(bus_b.op_rs_data), 64'h4_0000_0003);
        rd(5'd0, 5'd0);
        chk("rd_x0", 64'(bus_a.op_rs_data), 64'h0);

        // same-cycle forwarding vs one-cycle-late visibility
        wra(5'd9, 32'hDEAD_BEEF);
        rd(5'd9, 5'd0);
        chk("byp_a", 64'(bus_a.op_rs_data), 64'hDEAD_BEEF);
        chk("nob_old", 64'(bus_b.op_rs_data), 64'h0);
        tick();
        idle();
        rd(5'd9, 5'd0);
        chk("nob_new", 64'(bus_b.op_rs_data), 64'hDEAD_BEEF);

        // reserve x10, 3 idle cycles, port-B completion
        rsv(5'd10);
        rd(5'd10, 5'd10);
        chk("rsv_pre", 64'(bus_a.op_rs_busy), 64'h0);
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            rd(5'd10, 5'd10);
            chk("rsv_vec", 64'(bus_a.op_busy_vec[10]), 64'h1);
            chk("rsv_rs", 64'(bus_a.op_rs_busy), 64'h3);
            tick();
        end
        wrb(5'd10, 32'h1234);
        rd(5'd10, 5'd0);
        chk("wrb_rs_byp", 64'(bus_a.op_rs_busy), 64'h0);
        chk("wrb_rs_nob", 64'(bus_b.op_rs_busy), 64'h1);
        chk("wrb_vec_hold", 64'(bus_a.op_busy_vec[10]), 64'h1);
        chk("wrb_fwd", 64'(bus_a.op_rs_data), 64'h1234);
        tick();
        idle();
        rd(5'd10, 5'd0);
        chk("wrb_vec_clr", 64'(bus_a.op_busy_vec[10]), 64'h0);
        chk("wrb_data", 64'(bus_b.op_rs_data), 64'h1234);
        chk("wrb_err", 64'(bus_a.op_err), 64'h0);

        // rsv overrides a same-cycle B clear
        wrb(5'd11, 32'h55);
        rsv(5'd11);
        tick();
        idle();
        rd(5'd11, 5'd0);
        chk("x11_busy", 64'(bus_a.op_busy_vec[11]), 64'h1);
        chk("x11_data", 64'(bus_a.op_rs_data), 64'h55);
        chk("x11_err", 64'(bus_a.op_err), 64'h0);

        // re-reserve a busy register
        rsv(5'd11);
        tick();
        idle();
        chk("rsv2_err", 64'(bus_a.op_err), 64'h1);
        tick();
        chk("rsv2_err_end", 64'(bus_a.op_err), 64'h0);

        // A and B on the same address
        wra(5'd12, 32'hA);
        wrb(5'd12, 32'hB);
        tick();
        idle();
        rd(5'd12, 5'd0);
        chk("ab_err", 64'(bus_a.op_err), 64'h1);
        chk("ab_data", 64'(bus_a.op_rs_data), 64'hA);
        tick();
        chk("ab_err_end", 64'(bus_a.op_err), 64'h0);

        // WAW: A writes busy x13
        rsv(5'd13);
        tick();
        idle();
        wra(5'd13, 32'h13);
        tick();
        idle();
        rd(5'd13, 5'd0);
        chk("waw_err", 64'(bus_a.op_err), 64'h1);
        chk("waw_data", 64'(bus_a.op_rs_data), 64'h13);
        chk("waw_busy", 64'(bus_a.op_busy_vec[13]), 64'h1);
        tick();
        chk("waw_err_end", 64'(bus_a.op_err), 64'h0);

        // x0 ignores writes and reservations
        wra(5'd0, 32'hFFFF);
        rsv(5'd0);
        rd(5'd0, 5'd0);
        chk("x0_fwd", 64'(bus_a.op_rs_data), 64'h0);
        tick();
        idle();
        chk("x0_data", 64'(bus_a.op_rs_data), 64'h0);
        chk("x0_busy", 64'(bus_a.op_busy_vec[0]), 64'h0);
        chk("x0_err", 64'(bus_a.op_err), 64'h0);

        // mid-operation reset
        rsv(5'd14);
        wra(5'd15, 32'h7);
        tick();
        idle();
        rd(5'd15, 5'd14);
        chk("pre_rst_x15", 64'(bus_a.op_rs_data), 64'h7);
        chk("pre_rst_x14", 64'(bus_a.op_busy_vec[14]), 64'h1);
        ip_rst_tb = 1'b1;
        wra(5'd12, 32'hA);
        wrb(5'd12, 32'hB);
        tick();
        ip_rst_tb = 1'b0;
        idle();
        rd(5'd15, 5'd12);
        chk("rst2_data", 64'(bus_a.op_rs_data), 64'h0);
        chk("rst2_busy", 64'(bus_a.op_busy_vec), 64'h0);
        chk("rst2_err", 64'(bus_a.op_err), 64'h0);
        rd(5'd5, 5'd9);
        chk("rst2_x5_x9", 64'(bus_b.op_rs_data), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised RV32IM general register file with a configurable number of read ports, two write ports and a per-register busy scoreboard. Write port A serves single-cycle ALU/load writeback. Write port B serves the multi-cycle MUL/DIV unit. The scoreboard marks a destination register busy from MUL/DIV issue until its port-B writeback, so decode can stall on true dependencies. The block sits between decode (reads, reservations) and writeback (writes), replacing the fixed 2-read/1-write register file.

## Interface
Parameters:
- DATA_W, 32, register width
- ADDR_W, 5, address width; depth is 2**ADDR_W
- NUM_RD, 2, number of read ports (legal range 1..4)
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = read sees write one cycle later

Ports:
- ip_clk  in  1  clock; all state updates on rising edge
- ip_rst  in  1  reset, synchronous, active-high
- ip_rs_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
- op_rs_data  out  NUM_RD*DATA_W  packed read data, combinational
- op_rs_busy  out  NUM_RD  per-port busy flag for the addressed register, combinational
- ip_wra_en, ip_wra_addr (ADDR_W), ip_wra_data (DATA_W)  in  write port A
- ip_wrb_en, ip_wrb_addr (ADDR_W), ip_wrb_data (DATA_W)  in  write port B (MUL/DIV); clears busy
- ip_rsv_en, ip_rsv_addr (ADDR_W)  in  reserve: set busy for the destination of an issued MUL/DIV
- op_busy_vec  out  2**ADDR_W  registered busy bits; bit 0 is always 0
- op_err  out  1  registered one-cycle error pulse (see Operation)

## Operation
- Register 0 is hardwired to zero. Writes to it are ignored, reservations of it are ignored, and it is never busy.
- Reads are combinational from the array. For each port, the lookup priority is:
  - address 0 -> data 0;
  - else, if BYPASS and a write port is writing this address this cycle -> that write data, with port A taking priority over port B;
  - else the stored value.
- Busy for each read port = busy[addr], except that with BYPASS=1 it is forced to 0 when port B is writing that address this cycle.
- Writes commit at the rising edge.
  - If A and B target the same nonzero address in the same cycle, A's data is stored (A is the younger instruction).
- Busy update per register r != 0, evaluated at each edge:
  - rsv to r -> set (this overrides a same-cycle port-B clear of r);
  - else port-B write to r -> clear;
  - else hold.
- op_err pulses high for one cycle, in the cycle after the edge at which any of these occurred:
  - A and B write the same nonzero address;
  - rsv targets a register already busy and not being cleared that cycle;
  - port A writes a busy register (WAW hazard). The data is still written and busy is unchanged.
- Reset: every register, every busy bit and op_err are cleared to 0 at the first rising edge with ip_rst=1. While ip_rst is held, all writes and reservations are ignored.

## Timing
- Read latency: 0 cycles (combinational from address).
- Write-to-read: same cycle with BYPASS=1; the cycle after the write edge with BYPASS=0.
- Reserve-to-busy: op_busy_vec and op_rs_busy assert the cycle after the rsv edge.
- Port-B clear: op_busy_vec deasserts the cycle after the write edge. op_rs_busy deasserts in the write cycle itself when BYPASS=1.
- op_err: a registered single-cycle pulse; it stays high for consecutive cycles only if the error repeats.
- Reset mid-operation: pending reservations are dropped. No port-B completion is expected after reset, and a late port-B write is treated as an ordinary write (busy already 0).

## Test plan
- Reset, then write x5=1, x6=2, x7=3, x8=4 via port A on consecutive cycles. Read rs0=x5, rs1=x6 -> data 1/2. Read x7/x8 -> 3/4. Read x0 -> 0.
- BYPASS=1: port A writes x9=0xDEADBEEF while rs0=x9 in the same cycle -> op_rs_data port 0 = 0xDEADBEEF in that cycle. BYPASS=0 -> old value (0), then 0xDEADBEEF the next cycle.
- Reserve x10, then 3 idle cycles, then port B writes x10=0x1234:
  - op_busy_vec[10]=1 from the cycle after the reservation;
  - op_rs_busy=1 on a port reading x10 until the write cycle (BYPASS=1);
  - data 0x1234 is returned, then busy=0.
- Same-cycle port-B write of x11 and rsv of x11 -> busy[11] stays 1 and x11 holds the B data.
- A and B both write x12 (A=0xA, B=0xB) in one cycle -> x12=0xA and op_err=1 for exactly one cycle. Port A writes busy x13 -> op_err pulse, data written, busy[13] still 1.
- Write x0=0xFFFF and rsv x0 -> x0 reads 0 and op_busy_vec[0]=0. Assert ip_rst with x14 busy and x15=7 -> next cycle all registers read 0, op_busy_vec=0, op_err=0.
